// File: rtl/sample_quantizer.sv
// sample_quantizer
//   Decimates a 12-bit offset-binary sample stream by DECIM and converts each
//   kept sample to 8-bit signed two's complement. Results go through a
//   2-entry FIFO with a valid/ready handshake toward the consumer. Samples
//   that arrive while the FIFO is full and not draining are dropped and
//   counted.
//
//   Build option: define SAT_ROUND_EN to round to nearest and saturate to
//   -128..+127. Without it the 8-bit result is a plain truncation, bits [11:4].
//
//   Parameter
//     DECIM      decimation ratio, 1..256 (default 16)
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     in_en      in_data qualifier
//     in_data    12-bit offset-binary sample, 0x800 = zero
//     out_valid  out_data holds a valid sample (oldest FIFO entry)
//     out_ready  consumer accepts out_data this cycle
//     out_data   8-bit signed sample
//     drop_cnt   number of dropped samples, saturates at 255
//     overflow   sticky: at least one sample dropped since reset
module sample_quantizer #(
  parameter int DECIM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);

  // DECIM=1 still needs a 1-bit counter; it simply stays at 0.
  localparam int            CW       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Offset-binary to signed (invert MSB), then reduce 12 -> 8 bits.
  function automatic logic [7:0] quantize(input logic [11:0] d);
    logic [11:0] s;
`ifdef SAT_ROUND_EN
    logic [12:0] sum;
    logic [8:0]  shr;
`endif
    s = {~d[11], d[10:0]};
`ifdef SAT_ROUND_EN
    // Sign-extend to 13 bits so +8 cannot wrap; bits [12:4] are the
    // arithmetic shift by 4, a 9-bit signed value in -128..+128.
    sum = {s[11], s} + 13'd8;
    shr = sum[12:4];
    if (!shr[8] && shr[7]) begin
      quantize = 8'h7F;
    end else if (shr[8] && !shr[7]) begin
      quantize = 8'h80;
    end else begin
      quantize = shr[7:0];
    end
`else
    quantize = s[11:4];
`endif
  endfunction

  logic [CW-1:0] r_cnt;
  fifo_state_t   r_state;
  fifo_state_t   w_state_next;
  logic [7:0]    r_head;
  logic [7:0]    r_tail;
  logic          r_valid;
  logic [7:0]    r_drop_cnt;
  logic          r_overflow;

  logic          w_capture;
  logic          w_pop;
  logic [7:0]    w_q;
  logic          w_load_head;
  logic          w_head_from_tail;
  logic          w_load_tail;
  logic          w_drop;

  assign w_capture = in_en && (r_cnt == CNT_LAST);
  assign w_pop     = r_valid && out_ready;
  assign w_q       = quantize(in_data);

  // Decimation counter; advances on every enabled input, ignores backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // FIFO occupancy next state and datapath steering.
  always_comb begin
    w_state_next     = r_state;
    w_load_head      = 1'b0;
    w_head_from_tail = 1'b0;
    w_load_tail      = 1'b0;
    w_drop           = 1'b0;
    case (r_state)
      EMPTY: begin
        // out_valid is low here, so no pop can coincide with this push.
        if (w_capture) begin
          w_load_head  = 1'b1;
          w_state_next = ONE;
        end else begin
          w_state_next = EMPTY;
        end
      end
      ONE: begin
        if (w_capture && w_pop) begin
          w_load_head  = 1'b1;
          w_state_next = ONE;
        end else if (w_capture) begin
          w_load_tail  = 1'b1;
          w_state_next = FULL;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end else begin
          w_state_next = ONE;
        end
      end
      FULL: begin
        if (w_capture && w_pop) begin
          w_head_from_tail = 1'b1;
          w_load_tail      = 1'b1;
          w_state_next     = FULL;
        end else if (w_capture) begin
          w_drop       = 1'b1;
          w_state_next = FULL;
        end else if (w_pop) begin
          w_head_from_tail = 1'b1;
          w_state_next     = ONE;
        end else begin
          w_state_next = FULL;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  // FIFO state register and registered out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= (w_state_next != EMPTY);
    end
  end

  // FIFO storage: head is the oldest entry and drives out_data directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= 8'h00;
      r_tail <= 8'h00;
    end else begin
      if (w_load_head) begin
        r_head <= w_q;
      end else if (w_head_from_tail) begin
        r_head <= r_tail;
      end else begin
        r_head <= r_head;
      end
      if (w_load_tail) begin
        r_tail <= w_q;
      end else begin
        r_tail <= r_tail;
      end
    end
  end

  // Drop counter (saturating) and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'h00;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      r_overflow <= 1'b1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
      r_overflow <= r_overflow;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_head;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sample_quantizer.sv
module tb_sample_quantizer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_cnt;
  logic [7:0] m_q[$];
  int         m_drop;
  bit         m_ovf;

  always #5 clk = ~clk;

  sample_quantizer #(.DECIM(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  function automatic int floor_div16(input int v);
    return (v - (((v % 16) + 16) % 16)) / 16;
  endfunction

  // Expected 8-bit result from the arithmetic definition.
  function automatic logic [7:0] ref_q(input logic [11:0] d);
    int s;
    int r;
    s = int'(d) - 2048;
`ifdef SAT_ROUND_EN
    r = floor_div16(s + 8);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`else
    r = floor_div16(s);
`endif
    return 8'(r);
  endfunction

  // Drive one cycle of inputs, advance the model across the clock edge,
  // and leave time at posedge+1 for sampling.
  task automatic step(input bit r, input bit e, input logic [11:0] d, input bit rdy);
    rst       = r;
    in_en     = e;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_cnt  = 0;
      m_q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (e) begin
        if (m_cnt == D - 1) begin
          if (m_q.size() < 2) begin
            m_q.push_back(ref_q(d));
          end else begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1'b1;
          end
        end
        m_cnt = (m_cnt + 1) % D;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 12'h000, 1'b0);
    step(1'b1, 1'b1, 12'hFFF, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_zero_stream;
    int pulses;
    pulses = 0;
    step(1'b1, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 12'h800, 1'b1);
      checks++;
      if (out_valid !== (m_q.size() > 0)) begin
        errors++; $display("FAIL zero_valid cyc %0d: got %b want %b", i, out_valid, m_q.size() > 0);
      end
      if (out_valid === 1'b1) begin
        pulses++;
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL zero_data: got %h want 00", out_data); end
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL zero_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_conversion;
    logic [11:0] vec [8];
    logic [7:0]  lit [3];
    vec[0] = 12'h808; vec[1] = 12'hFFC; vec[2] = 12'h002;
    for (int i = 3; i < 8; i++) vec[i] = 12'($urandom);
`ifdef SAT_ROUND_EN
    lit[0] = 8'h01;
`else
    lit[0] = 8'h00;
`endif
    lit[1] = 8'h7F; lit[2] = 8'h80;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 12'h000, 1'b1);
      for (int k = 0; k < D; k++) step(1'b0, 1'b1, vec[i], 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv_valid %h: got %b want 1", vec[i], out_valid); end
      checks++; if (out_data !== ref_q(vec[i])) begin errors++; $display("FAIL conv_data %h: got %h want %h", vec[i], out_data, ref_q(vec[i])); end
      if (i < 3) begin
        checks++; if (out_data !== lit[i]) begin errors++; $display("FAIL conv_lit %h: got %h want %h", vec[i], out_data, lit[i]); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e1;
    step(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 3 * D; i++) begin
      step(1'b0, 1'b1, 12'($urandom), 1'b0);
      if (m_q.size() > 0) begin
        checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL bp_hold cyc %0d: got %h want %h", i, out_data, m_q[0]); end
      end
    end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop: got %0d want 1", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", overflow); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    e1 = m_q[1];
    step(1'b0, 1'b0, 12'h000, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== e1) begin errors++; $display("FAIL bp_second: got %b/%h want 1/%h", out_valid, out_data, e1); end
    step(1'b0, 1'b0, 12'h000, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_full_pop;
    logic [11:0] v;
    logic [7:0]  e0;
    v = 12'($urandom);
    step(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 2 * D + D - 1; i++) step(1'b0, 1'b1, 12'($urandom), 1'b0);
    e0 = m_q[1];
    step(1'b0, 1'b1, v, 1'b1);
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fp_nodrop: got %0d/%b want 0/0", drop_cnt, overflow); end
    checks++; if (out_valid !== 1'b1 || out_data !== e0) begin errors++; $display("FAIL fp_head: got %b/%h want 1/%h", out_valid, out_data, e0); end
    step(1'b0, 1'b0, 12'h000, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== ref_q(v)) begin errors++; $display("FAIL fp_tail: got %b/%h want 1/%h", out_valid, out_data, ref_q(v)); end
    step(1'b0, 1'b0, 12'h000, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_toggle;
    int pulses;
    int last;
    pulses = 0;
    last = -1;
    step(1'b1, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, (i % 2) == 0, 12'($urandom), 1'b1);
      checks++;
      if (out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL tog_valid cyc %0d: got %b want %b", i, out_valid, m_q.size() > 0); end
      if (out_valid === 1'b1) begin
        if (last >= 0) begin
          checks++; if (i - last != 8) begin errors++; $display("FAIL tog_gap: got %0d want 8", i - last); end
        end
        last = i;
        pulses++;
      end
    end
    checks++; if (pulses != 8) begin errors++; $display("FAIL tog_pulses: got %0d want 8", pulses); end
  endtask

  task automatic test_rst_full;
    logic [11:0] v;
    step(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 7 * D; i++) step(1'b0, 1'b1, 12'($urandom), 1'b0);
    checks++; if (drop_cnt !== 8'd5 || overflow !== 1'b1) begin errors++; $display("FAIL rf_pre: got %0d/%b want 5/1", drop_cnt, overflow); end
    step(1'b1, 1'b1, 12'hABC, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rf_data: got %h want 00", out_data); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rf_drop: got %0d want 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rf_ovf: got %b want 0", overflow); end
    v = 12'($urandom);
    for (int k = 0; k < D; k++) begin
      step(1'b0, 1'b1, v, 1'b1);
      checks++;
      if (out_valid !== (k == D - 1)) begin errors++; $display("FAIL rf_restart cyc %0d: got %b want %b", k, out_valid, k == D - 1); end
    end
    checks++; if (out_data !== ref_q(v)) begin errors++; $display("FAIL rf_restart_data: got %h want %h", out_data, ref_q(v)); end
  endtask

  task automatic test_drop_saturate;
    step(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 262 * D; i++) step(1'b0, 1'b1, 12'($urandom), 1'b0);
    checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL sat_model: got %0d want %0d", drop_cnt, m_drop); end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_random;
    step(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom % 4) != 0, 12'($urandom), ($urandom % 3) == 0);
      checks++;
      if (out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", i, out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL rnd_data cyc %0d: got %h want %h", i, out_data, m_q[0]); end
      end
      checks++;
      if (drop_cnt !== 8'(m_drop) || overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_drop cyc %0d: got %0d/%b want %0d/%b", i, drop_cnt, overflow, m_drop, m_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; in_data = 12'h000; out_ready = 1'b0;
    m_cnt = 0; m_drop = 0; m_ovf = 1'b0;
    test_reset();
    test_zero_stream();
    test_conversion();
    test_backpressure();
    test_full_pop();
    test_toggle();
    test_rst_full();
    test_drop_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_quantizer.md
SAMPLE_QUANTIZER -- requirements
Module: sample_quantizer

Interface
REQ-001 SHALL have parameter DECIM, default 16, decimation ratio; legal range 1..256.
REQ-002 SHALL have port clk  input  1  system clock (12 MHz); all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_en  input  1  qualifies in_data this cycle; same timing as the triangle generator's enable.
REQ-005 SHALL have port in_data  input  12  offset-binary sample from the wave generator; 0x800 = zero.
REQ-006 SHALL have port out_valid  output  1  out_data holds a valid 8-bit sample.
REQ-007 SHALL have port out_ready  input  1  consumer (8-bit lattice filter) accepts out_data this cycle.
REQ-008 SHALL have port out_data  output  8  signed two's-complement sample.
REQ-009 SHALL have port drop_cnt  output  8  count of samples discarded for lack of buffer space.
REQ-010 SHALL have port overflow  output  1  sticky flag: at least one sample dropped since reset.

Function
REQ-011 SHALL keep a decimation counter 0..DECIM-1, incremented only on cycles with in_en=1, wrapping DECIM-1 -> 0.
REQ-012 SHALL capture in_data on an in_en=1 cycle where the counter equals DECIM-1; with DECIM=1, SHALL capture every in_en=1 cycle.
REQ-013 SHALL convert a captured sample to signed 12 bits as in_data minus 0x800 (invert MSB).
REQ-014 SHALL reduce the 12-bit signed value to 8 bits per REQ-025/REQ-026.
REQ-015 SHALL hold converted samples in a 2-entry FIFO with occupancy states EMPTY, ONE, FULL.
REQ-016 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop without push; ONE/FULL unchanged on simultaneous push and pop.
REQ-017 SHALL assert out_valid in states ONE and FULL, with out_data equal to the oldest entry.
REQ-018 SHALL pop on a cycle where out_valid=1 and out_ready=1.
REQ-019 SHALL present out_data on out_valid the cycle after capture when the FIFO was EMPTY; latency is one clock.
REQ-020 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL accept a capture in state FULL when a pop occurs in the same cycle.
REQ-022 SHALL, on a capture in state FULL with no pop, discard the new sample, increment drop_cnt saturating at 255, and set overflow.
REQ-023 SHALL keep the decimation counter running independently of out_ready; backpressure never stalls it.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, clear the decimation counter, empty the FIFO, and force out_valid=0, out_data=0x00, drop_cnt=0 and overflow=0; in_en is ignored that cycle, any stored sample is discarded, and capture restarts from counter 0 on the first cycle with rst=0.

Configuration
REQ-025 SHALL, when macro SAT_ROUND_EN is defined, add 8 to the signed 12-bit value, arithmetic-shift right 4, and saturate the result to -128..+127.
REQ-026 SHALL, when SAT_ROUND_EN is undefined, truncate, taking signed bits [11:4] with no rounding and no saturation logic.

Verification
REQ-027 SHALL cover: DECIM=4, in_en=1 every cycle, in_data=0x800, out_ready=1 -> out_valid pulses once every 4 cycles with out_data=0x00.
REQ-028 SHALL cover: in_data=0x808 -> out_data=0x01 with SAT_ROUND_EN, 0x00 without; in_data=0xFFC -> out_data=0x7F both builds; in_data=0x002 -> out_data=0x80 both builds.
REQ-029 SHALL cover: out_ready=0, three captures -> first two samples retained in order, third dropped, drop_cnt=1, overflow=1; then out_ready=1 -> two pops, out_valid drops.
REQ-030 SHALL cover: FIFO FULL with capture and pop in the same cycle -> no drop, drop_cnt unchanged, FIFO remains FULL.
REQ-031 SHALL cover: in_en toggled 1/0 each cycle with DECIM=4 -> one capture per 4 enabled cycles, i.e. every 8 clocks.
REQ-032 SHALL cover: rst=1 for one cycle while FULL with drop_cnt=5 -> next cycle out_valid=0, out_data=0x00, drop_cnt=0, overflow=0.
